// File: rtl/ext.sv
`default_nettype none
// ============================================================================
// Module   : ext
// Purpose  : Registered immediate extender; zero/sign-extends a 5, 8 or
//            11-bit instruction field to 16 bits and flags an illegal width.
// Revision : 1.0  initial release
// ============================================================================
module ext (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] instr,
  input  logic [1:0]  select,
  input  logic        op,
  output logic [15:0] imm,
  output logic        err
);

  localparam logic [1:0] c_SEL_5  = 2'b00;
  localparam logic [1:0] c_SEL_8  = 2'b01;
  localparam logic [1:0] c_SEL_11 = 2'b10;

  logic [15:0] w_imm;
  logic        w_err;
  logic [15:0] r_imm;
  logic        r_err;

  // Any select outside the three legal codes (including X) takes the
  // default arm, so an unknown select is never treated as a legal width.
  always_comb begin
    w_imm = 16'h0000;
    w_err = 1'b0;
    case (select)
      c_SEL_5:  w_imm = {{11{op & instr[4]}},  instr[4:0]};
      c_SEL_8:  w_imm = {{8{op & instr[7]}},   instr[7:0]};
      c_SEL_11: w_imm = {{5{op & instr[10]}},  instr[10:0]};
      default: begin
        w_imm = 16'h0000;
        w_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_imm <= 16'h0000;
      r_err <= 1'b0;
    end else begin
      r_imm <= w_imm;
      r_err <= w_err;
    end
  end

  assign imm = r_imm;
  assign err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ext.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext
// Purpose  : Self-checking bench for ext: directed cases plus randomized
//            vectors against an arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ext;

  logic        clk;
  logic        rst;
  logic [10:0] instr;
  logic [1:0]  select;
  logic        op;
  logic [15:0] imm;
  logic        err;

  int total = 0;
  int bad   = 0;

  ext u_dut (
    .clk    (clk),
    .rst    (rst),
    .instr  (instr),
    .select (select),
    .op     (op),
    .imm    (imm),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: take the field modulo 2^w; a negative value under sign
  // extension is the two's-complement value wrapped into 16 bits.
  function automatic void model(input int unsigned ins, input int unsigned sel,
                                input int unsigned o,
                                output logic [15:0] e_imm, output logic e_err);
    int unsigned w, src;
    int unsigned res;
    e_err = 1'b0;
    case (sel)
      0: w = 5;
      1: w = 8;
      2: w = 11;
      default: w = 0;
    endcase
    if (w == 0) begin
      e_imm = 16'h0000;
      e_err = 1'b1;
    end else begin
      src = ins % (1 << w);
      if (o != 0 && src >= (1 << (w - 1))) res = src + 65536 - (1 << w);
      else res = src;
      e_imm = res[15:0];
    end
  endfunction

  task automatic apply(input logic [10:0] i, input logic [1:0] s, input logic o);
    @(negedge clk);
    instr  = i;
    select = s;
    op     = o;
    @(posedge clk);
    #1;
  endtask

  task automatic step_check(input string tag, input logic [10:0] i,
                            input logic [1:0] s, input logic o);
    logic [15:0] e_imm;
    logic        e_err;
    apply(i, s, o);
    model(32'(i), 32'(s), 32'(o), e_imm, e_err);
    chk({tag, "_imm"}, imm, e_imm);
    chk({tag, "_err"}, {15'd0, err}, {15'd0, e_err});
  endtask

  localparam logic [10:0] c_VEC = 11'b101_1101_0101;

  initial begin
    logic [15:0] e_imm;
    logic        e_err;
    logic [10:0] ri;
    logic [1:0]  rs;
    logic        ro;

    rst = 1'b1; instr = '0; select = 2'b00; op = 1'b0;
    #3;
    chk("reset_imm", imm, 16'h0000);
    chk("reset_err", {15'd0, err}, 16'h0000);
    @(posedge clk); #1;
    chk("reset_hold_imm", imm, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Known-answer cases
    apply(c_VEC, 2'b00, 1'b0); chk("kat5z", imm, 16'h0015); chk("kat5z_err", {15'd0, err}, 16'h0000);
    apply(c_VEC, 2'b00, 1'b1); chk("kat5s", imm, 16'hFFF5);
    apply(c_VEC, 2'b01, 1'b0); chk("kat8z", imm, 16'h00D5);
    apply(c_VEC, 2'b01, 1'b1); chk("kat8s", imm, 16'hFFD5);
    apply(c_VEC, 2'b10, 1'b0); chk("kat11z", imm, 16'h05D5);
    apply(c_VEC, 2'b10, 1'b1); chk("kat11s", imm, 16'hFDD5); chk("kat11s_err", {15'd0, err}, 16'h0000);

    apply(c_VEC, 2'b11, 1'b0); chk("ill0_imm", imm, 16'h0000); chk("ill0_err", {15'd0, err}, 16'h0001);
    apply(c_VEC, 2'b11, 1'b1); chk("ill1_imm", imm, 16'h0000); chk("ill1_err", {15'd0, err}, 16'h0001);
    apply(c_VEC, 2'b00, 1'b0); chk("recov_imm", imm, 16'h0015); chk("recov_err", {15'd0, err}, 16'h0000);

    apply(11'b000_0000_1111, 2'b00, 1'b1); chk("pos_sext", imm, 16'h000F);
    apply(11'h7FF, 2'b00, 1'b1); chk("ones5", imm, 16'hFFFF);
    apply(11'h0FF, 2'b01, 1'b1); chk("ones8", imm, 16'hFFFF);
    apply(11'h7FF, 2'b10, 1'b1); chk("ones11", imm, 16'hFFFF);

    // Upper-bit isolation
    for (int k = 0; k < 8; k++) begin
      ri = {6'($urandom), 5'b10101};
      apply(ri, 2'b00, 1'b0);
      chk("iso", imm, 16'h0015);
    end

    // Asynchronous reset between edges
    apply(c_VEC, 2'b10, 1'b0);
    chk("pre_rst", imm, 16'h05D5);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_imm", imm, 16'h0000);
    chk("async_rst_err", {15'd0, err}, 16'h0000);
    @(posedge clk); #1;
    chk("rst_held_imm", imm, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_release_imm", imm, 16'h0000);
    @(posedge clk); #1;
    chk("first_after_rst", imm, 16'h05D5);

    // Randomized sweep
    for (int k = 0; k < 300; k++) begin
      ri = 11'($urandom);
      rs = 2'($urandom_range(0, 3));
      ro = 1'($urandom);
      step_check("rand", ri, rs, ro);
    end

    // No history: illegal then legal back-to-back in random order
    for (int k = 0; k < 20; k++) begin
      ri = 11'($urandom);
      apply(ri, 2'b11, 1'($urandom));
      chk("hist_ill_err", {15'd0, err}, 16'h0001);
      ro = 1'($urandom);
      apply(ri, 2'b01, ro);
      model(32'(ri), 32'd1, 32'(ro), e_imm, e_err);
      chk("hist_leg_imm", imm, e_imm);
      chk("hist_leg_err", {15'd0, err}, {15'd0, e_err});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
